alu_ext: RTL and testbench
==========================

# alu_ext

Parametrised successor to the CPU's accumulator/ALU slice: holds the A and B operand registers loaded from the shared bus, computes add/sub/add-with-carry/sub-with-borrow/AND/OR/XOR combinationally, and adds a multi-cycle shift-add multiplier with a start/busy/done handshake. Flags (C, Z, N, V) are held in a flags register written under microcode control, so ADC/SBC can chain multi-word arithmetic. The block sits between the bus and the control unit, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 8: datapath width in bits. Must be at least 2.
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `ctrl_ai`: input, 1 bit. Load `a_reg` from `bus`.
- `ctrl_bi`: input, 1 bit. Load `b_reg` from `bus`.
- `ctrl_fi`: input, 1 bit. Load the flags register from the current op's flag results.
- `ctrl_op`: input, 3 bits. 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MUL.
- `ctrl_start`: input, 1 bit. Starts a MUL. Sampled only when `ctrl_op` is 7.
- `bus`: input, WIDTH bits. Shared data bus.
- `a_reg`: output, WIDTH bits. A register.
- `b_reg`: output, WIDTH bits. B register.
- `result`: output, WIDTH bits. ALU result; for MUL, the product low half.
- `prod_hi`: output, WIDTH bits. Product high half.
- `flag_c`, `flag_z`, `flag_n`, `flag_v`: output, 1 bit each. Registered flags.
- `busy`: output, 1 bit. Multiplier running.
- `done`: output, 1 bit. One-cycle pulse when the product is valid.

## Operation
- **Operand registers**
  - `a_reg` loads `bus` on a clock edge when `ctrl_ai` is high; `b_reg` likewise with `ctrl_bi`.
  - Both can load in the same cycle.
  - Loads are permitted while `busy` is high; they do not disturb a running MUL.
- **Arithmetic ops**: WIDTH+1-bit sum `s = a + b' + cin`, with `result = s[WIDTH-1:0]`.
  - ADD: b' = b, cin = 0.
  - SUB: b' = ~b, cin = 1.
  - ADC: b' = b, cin = `flag_c`.
  - SBC: b' = ~b, cin = `flag_c`.
- **Arithmetic flag results**
  - C = s[WIDTH]. For SUB/SBC, 1 means no borrow.
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - V = (a[msb] == b'[msb]) && (result[msb] != a[msb]).
- **Logic ops** (AND, OR, XOR): bitwise on a and b; C = 0, V = 0; Z and N as above.
- **MUL**: unsigned WIDTH x WIDTH -> 2·WIDTH-bit product.
  - Flag results: Z = (full product == 0); C = V = (`prod_hi` != 0); N = `result`[WIDTH-1].
- **Flags register**
  - Written only on a clock edge with `ctrl_fi` high, taking the flag results of the current `ctrl_op`.
  - `ctrl_fi` with op 7 captures the flags of the held product register, whether or not a MUL is running.
- **Multiplier FSM**
  - IDLE:
    - `ctrl_start` with op 7 latches a and b into internal copies, clears the product, clears the iteration counter, and goes to RUN.
    - Otherwise stays in IDLE.
  - RUN:
    - One shift-add iteration per cycle, over exactly WIDTH iterations.
    - After the WIDTH-th iteration, go to DONE.
    - `ctrl_start` is ignored.
  - DONE:
    - The product register is valid and `done` is high.
    - Next state is RUN if a new start is accepted, otherwise IDLE.
  - The product register holds its value until the next accepted start or `reset`.
- **Outputs while `ctrl_op` = 7**: `result` and `prod_hi` show the product register, including partial values during RUN. `prod_hi` always shows the product high half regardless of op.

## Timing
- **Reset values**: `a_reg`, `b_reg`, `result` (for op 0), `prod_hi` are 0; all four flags are 0; `busy` and `done` are 0; FSM is in IDLE; counter is 0.
- **Reset mid-MUL**: `reset` asserted during RUN or DONE aborts immediately, clears all state as above, and produces no `done` pulse.
- **Combinational ops**: `result` is combinational from `a_reg`, `b_reg`, `flag_c` and `ctrl_op`. It is valid in the same cycle after the operand register updates.
- **Flag update**: flags update on the edge that samples `ctrl_fi`. An ADC in the cycle after `ctrl_fi` sees the new C.
- **MUL latency**, with the accepting start edge as T:
  - `busy` = 1 from T to T+WIDTH.
  - At T+WIDTH, `busy` = 0, `done` = 1 for exactly one cycle, and the product is valid.
- **Back-to-back MUL**: a start while `done` is high is accepted, giving the next `done` at T'+WIDTH.
- **Simultaneous start and load**: `ctrl_start` plus `ctrl_ai`/`ctrl_bi` on the same edge means the multiplier captures the pre-edge register values.

## Test plan
- **Reset**: assert `reset` asynchronously mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- **ADD with carry/zero**: WIDTH=8, A=0xFF, B=0x01, op ADD, `ctrl_fi` -> `result` 0x00; C=1, Z=1, N=0, V=0. Then A=0x7F, B=0x01 -> 0x80 with N=1, V=1, C=0.
- **SUB borrow and SBC chain**: A=0x05, B=0x07, SUB, `ctrl_fi` -> 0xFE with C=0, N=1. Then A=0x10, B=0x00, SBC -> 0x0F with C=1.
- **MUL timing**: A=0x0F, B=0x11, op 7, start at edge T -> `busy` high for 8 cycles; `done` a single pulse at T+8; `result` 0xFF, `prod_hi` 0x00; `ctrl_fi` -> C=0, N=1.
- **MUL high half and operand isolation**: A=0xFF, B=0xFF, start, then load A=0x00 during RUN -> product 0xFE01; `ctrl_fi` gives C=V=1, Z=0. Immediate restart during `done` gives the next `done` 8 cycles later.
- **Reset mid-MUL**: assert `reset` at T+3 -> `busy` 0, `prod_hi` 0, and no `done` pulse in the following 10 cycles.

Source files
------------

// File: rtl/alu_ext.sv
// alu_ext: operand registers, combinational ALU, registered flags and a
// multi-cycle shift-add multiplier with start/busy/done handshake.
module alu_ext #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_ai,
  input  logic             ctrl_bi,
  input  logic             ctrl_fi,
  input  logic [2:0]       ctrl_op,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] prod_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [2:0] OpMul = 3'd7;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               fc_q, fz_q, fn_q, fv_q;

  logic               start_ok;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   b_eff;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               fc_d, fz_d, fn_d, fv_d;

  // A start is only honoured when the multiplier is not mid-run.
  assign start_ok = ctrl_start && (ctrl_op == OpMul) && (state_q != StRun);

  // Operand registers; independent of the multiplier, which works on copies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (ctrl_ai) a_q <= bus;
      if (ctrl_bi) b_q <= bus;
    end
  end

  // One shift-add step: add multiplicand into the high half, shift right.
  always_comb begin
    acc = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  end

  // Multiplier next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_ok) begin
          mcand_d  = a_q;
          mplier_d = b_q;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        prod_d   = {acc, prod_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Multiplier state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // Adder operand selection; SUB/SBC use a + ~b + cin.
  always_comb begin
    b_eff = b_q;
    cin   = 1'b0;
    case (ctrl_op)
      3'd1:    begin b_eff = ~b_q; cin = 1'b1;   end
      3'd2:    begin b_eff = b_q;  cin = fc_q;   end
      3'd3:    begin b_eff = ~b_q; cin = fc_q;   end
      default: begin b_eff = b_q;  cin = 1'b0;   end
    endcase
    sum = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  end

  // Result and flag candidates for the current op.
  always_comb begin
    res  = sum[WIDTH-1:0];
    fc_d = sum[WIDTH];
    fv_d = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    case (ctrl_op)
      3'd4:    begin res = a_q & b_q; fc_d = 1'b0; fv_d = 1'b0; end
      3'd5:    begin res = a_q | b_q; fc_d = 1'b0; fv_d = 1'b0; end
      3'd6:    begin res = a_q ^ b_q; fc_d = 1'b0; fv_d = 1'b0; end
      3'd7: begin
        res  = prod_q[WIDTH-1:0];
        fc_d = |prod_q[2*WIDTH-1:WIDTH];
        fv_d = |prod_q[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
    fz_d = (ctrl_op == OpMul) ? (prod_q == '0) : (res == '0);
    fn_d = res[WIDTH-1];
  end

  // Flags register, written only under ctrl_fi.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fc_q <= 1'b0;
      fz_q <= 1'b0;
      fn_q <= 1'b0;
      fv_q <= 1'b0;
    end else if (ctrl_fi) begin
      fc_q <= fc_d;
      fz_q <= fz_d;
      fn_q <= fn_d;
      fv_q <= fv_d;
    end
  end

  assign a_reg   = a_q;
  assign b_reg   = b_q;
  assign result  = res;
  assign prod_hi = prod_q[2*WIDTH-1:WIDTH];
  assign flag_c  = fc_q;
  assign flag_z  = fz_q;
  assign flag_n  = fn_q;
  assign flag_v  = fv_q;
  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_alu_ext.sv
// Scoreboard bench for alu_ext (WIDTH=8): stimulus pushes expected snapshots,
// a monitor pops and compares them on the falling edge.
module tb_alu_ext;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctrl_ai = 1'b0, ctrl_bi = 1'b0, ctrl_fi = 1'b0, ctrl_start = 1'b0;
  logic [2:0] ctrl_op = 3'd0;
  logic [7:0] bus = 8'h00;
  logic [7:0] a_reg, b_reg, result, prod_hi;
  logic       flag_c, flag_z, flag_n, flag_v, busy, done;

  alu_ext #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .ctrl_ai(ctrl_ai), .ctrl_bi(ctrl_bi), .ctrl_fi(ctrl_fi),
    .ctrl_op(ctrl_op), .ctrl_start(ctrl_start), .bus(bus), .a_reg(a_reg), .b_reg(b_reg),
    .result(result), .prod_hi(prod_hi), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n),
    .flag_v(flag_v), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // mask bits: 0 a, 1 b, 2 result, 3 prod_hi, 4 flags {c,z,n,v}, 5 busy, 6 done
  typedef struct {
    string      name;
    logic [6:0] mask;
    logic [7:0] a, b, res, hi;
    logic [3:0] fl;
    logic       bsy, dn;
    bit         wait_done;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tstart;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(string name, logic [6:0] mask, logic [7:0] a, logic [7:0] b,
                              logic [7:0] res, logic [7:0] hi, logic [3:0] fl, logic bsy,
                              logic dn);
    exp_t e;
    e.name = name; e.mask = mask; e.a = a; e.b = b; e.res = res; e.hi = hi;
    e.fl = fl; e.bsy = bsy; e.dn = dn; e.wait_done = 1'b0; e.due = 0;
    return e;
  endfunction

  // Monitor: compares the head entry once the DUT presents it.
  initial begin : monitor
    exp_t e;
    bit   ok;
    logic [3:0] fl;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        if (sb[0].wait_done && !done) begin
          if (cyc > sb[0].due + 4) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: no done pulse by cycle %0d (required at cycle %0d)", e.name, cyc,
                     e.due);
          end
        end else begin
          e  = sb.pop_front();
          fl = {flag_c, flag_z, flag_n, flag_v};
          ok = 1'b1;
          if (e.mask[0] && a_reg !== e.a) ok = 1'b0;
          if (e.mask[1] && b_reg !== e.b) ok = 1'b0;
          if (e.mask[2] && result !== e.res) ok = 1'b0;
          if (e.mask[3] && prod_hi !== e.hi) ok = 1'b0;
          if (e.mask[4] && fl !== e.fl) ok = 1'b0;
          if (e.mask[5] && busy !== e.bsy) ok = 1'b0;
          if (e.mask[6] && done !== e.dn) ok = 1'b0;
          if (e.wait_done && cyc != e.due) ok = 1'b0;
          checks++;
          if (!ok) begin
            errors++;
            $display({"FAIL %s (mask %b): got a=%h b=%h res=%h hi=%h cznv=%b busy=%b done=%b ",
                      "cyc=%0d; required a=%h b=%h res=%h hi=%h cznv=%b busy=%b done=%b cyc=%0d"},
                     e.name, e.mask, a_reg, b_reg, result, prod_hi, fl, busy, done, cyc,
                     e.a, e.b, e.res, e.hi, e.fl, e.bsy, e.dn, e.wait_done ? e.due : cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until the monitor has consumed every queued entry.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left unchecked, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk(exp_t e);
    sb.push_back(e);
    drain();
  endtask

  task automatic chk_done(string name, logic [7:0] res, logic [7:0] hi, logic [7:0] a, int due);
    exp_t e;
    e = mk(name, 7'b1101101, a, 8'h00, res, hi, 4'b0000, 1'b0, 1'b1);
    e.wait_done = 1'b1;
    e.due = due;
    chk(e);
  endtask

  task automatic load(logic [7:0] a, logic [7:0] b);
    ctrl_ai = 1'b1; bus = a; step();
    ctrl_ai = 1'b0; ctrl_bi = 1'b1; bus = b; step();
    ctrl_bi = 1'b0;
  endtask

  task automatic cap_flags();
    ctrl_fi = 1'b1; step(); ctrl_fi = 1'b0;
  endtask

  // Logic-op table: op, a, b, expected result
  logic [2:0] lt_op  [3] = '{3'd4, 3'd5, 3'd6};
  logic [7:0] lt_res [3] = '{8'h30, 8'hFC, 8'hCC};

  initial begin : stim
    step(); step();
    reset = 1'b0;
    step();
    chk(mk("reset_state", 7'b1111111, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0));

    // ADD carry/zero, then overflow
    ctrl_op = 3'd0;
    load(8'hFF, 8'h01);
    chk(mk("add_ff_01", 7'b0000111, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0));
    cap_flags();
    chk(mk("add_ff_01_flags", 7'b0010000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1100, 1'b0, 1'b0));
    load(8'h7F, 8'h01);
    chk(mk("add_7f_01", 7'b0000100, 8'h00, 8'h00, 8'h80, 8'h00, 4'b0000, 1'b0, 1'b0));
    cap_flags();
    chk(mk("add_7f_01_flags", 7'b0010000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0011, 1'b0, 1'b0));

    // SUB with borrow, then SBC consuming C=0, then ADC consuming C=1
    ctrl_op = 3'd1;
    load(8'h05, 8'h07);
    chk(mk("sub_05_07", 7'b0000100, 8'h00, 8'h00, 8'hFE, 8'h00, 4'b0000, 1'b0, 1'b0));
    cap_flags();
    chk(mk("sub_flags", 7'b0010000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b0));
    ctrl_op = 3'd3;
    load(8'h10, 8'h00);
    chk(mk("sbc_10_00", 7'b0000100, 8'h00, 8'h00, 8'h0F, 8'h00, 4'b0000, 1'b0, 1'b0));
    cap_flags();
    chk(mk("sbc_flags", 7'b0010000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1000, 1'b0, 1'b0));
    ctrl_op = 3'd2;
    step();
    chk(mk("adc_new_carry", 7'b0000100, 8'h00, 8'h00, 8'h11, 8'h00, 4'b0000, 1'b0, 1'b0));

    // Logic ops
    load(8'hF0, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      ctrl_op = lt_op[i];
      step();
      chk(mk($sformatf("logic_op%0d", lt_op[i]), 7'b0000100, 8'h00, 8'h00, lt_res[i], 8'h00,
             4'b0000, 1'b0, 1'b0));
    end
    cap_flags();
    chk(mk("xor_flags", 7'b0010000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0010, 1'b0, 1'b0));
    ctrl_op = 3'd4;
    load(8'hF0, 8'h0F);
    cap_flags();
    chk(mk("and_zero_flags", 7'b0010100, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b0, 1'b0));

    // MUL 0x0F * 0x11 = 0x00FF
    load(8'h0F, 8'h11);
    ctrl_op = 3'd7; ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0; tstart = cyc;
    for (int i = 0; i < 8; i++) begin
      chk(mk($sformatf("mul1_busy%0d", i), 7'b1100000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000,
             1'b1, 1'b0));
      if (i < 7) step();
    end
    chk_done("mul1_done", 8'hFF, 8'h00, 8'h0F, tstart + 8);
    cap_flags();
    chk(mk("mul1_after", 7'b1111100, 8'h00, 8'h00, 8'hFF, 8'h00, 4'b0010, 1'b0, 1'b0));

    // MUL 0xFF * 0xFF with A reloaded to 0 mid-run
    load(8'hFF, 8'hFF);
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0; tstart = cyc;
    for (int i = 0; i < 8; i++) begin
      chk(mk($sformatf("mul2_busy%0d", i), 7'b1100000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000,
             1'b1, 1'b0));
      if (i == 1) begin ctrl_ai = 1'b1; bus = 8'h00; end
      if (i < 7) step();
      ctrl_ai = 1'b0;
    end
    chk_done("mul2_done", 8'h01, 8'hFE, 8'h00, tstart + 8);

    // Restart during done (A=0, B=FF) while capturing the held product flags
    ctrl_start = 1'b1; ctrl_fi = 1'b1;
    step();
    ctrl_start = 1'b0; ctrl_fi = 1'b0; tstart = cyc;
    chk(mk("mul2_flags_restart", 7'b0111000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1001, 1'b1,
           1'b0));
    chk_done("mul3_done", 8'h00, 8'h00, 8'h00, tstart + 8);
    cap_flags();
    chk(mk("mul3_flags", 7'b0010000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b0, 1'b0));

    // Reset asserted mid-cycle during RUN
    load(8'hFF, 8'hFF);
    ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    step(); step(); step();
    #2;
    reset = 1'b1;
    chk(mk("reset_mid_mul", 7'b1111111, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk(mk($sformatf("no_done_after_reset%0d", i), 7'b1101000, 8'h00, 8'h00, 8'h00, 8'h00,
             4'b0000, 1'b0, 1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
